// File: rtl/intra_pkg.sv
// rtl/intra_pkg.sv - shared types and constants for the intra mode decision controller
package intra_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_FIRST = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LAST  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/intra_mode_pick.sv
// rtl/intra_mode_pick.sv - combinational lowest-set-bit encoder over the pending mode mask
module intra_mode_pick
    import intra_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]      bits,
    output logic [MODE_W-1:0] idx,
    output logic              any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = MODE_FIRST;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = MODE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intra_mode_ctrl.sv
// rtl/intra_mode_ctrl.sv - intra mode decision FSM; optional SAD watchdog under INTRA_TIMEOUT_EN
module intra_mode_ctrl
    import intra_pkg::*;
#(
    parameter int NUM_MODES   = 8,
    parameter int SAD_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [NUM_MODES-1:0] mode_mask,
    output logic                 sad_req,
    output logic [MODE_W-1:0]    sad_mode,
    input  logic                 sad_ack,
    input  logic                 sad_valid,
    input  logic [SAD_W-1:0]     sad_value,
    output logic                 best_valid,
    input  logic                 best_ready,
    output logic [MODE_W-1:0]    best_mode,
    output logic [SAD_W-1:0]     best_sad,
    output logic                 busy,
    output logic                 timeout_err
);

    state_t                state, state_nxt;
    logic [NUM_MODES-1:0]  pending, pend_clr, pick_in;
    logic [MODE_W-1:0]     pick_idx;
    logic                  pick_any;
    logic [SAD_W-1:0]      run_min, eff_sad;
    logic [MODE_W-1:0]     run_mode;
    logic                  to_hit, wait_done;

    // Idle: encode the incoming mask; otherwise encode what remains once the current mode retires.
    assign pend_clr = pending & ~(NUM_MODES'(1) << sad_mode);
    assign pick_in  = (state == IDLE) ? mode_mask : pend_clr;

    intra_mode_pick #(.N(NUM_MODES)) u_pick (
        .bits (pick_in),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign wait_done = (state == WAIT) && (sad_valid || to_hit);
    assign eff_sad   = sad_valid ? sad_value : '1;

`ifdef INTRA_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        err_q;

    assign to_hit      = (state == WAIT) && !sad_valid && (wd_cnt >= 32'(TIMEOUT_CYC - 1));
    assign timeout_err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT && !wait_done) ? wd_cnt + 32'd1 : '0;
            if (to_hit) err_q <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_valid) state_nxt = pick_any ? ISSUE : DONE;
            ISSUE: if (sad_ack)     state_nxt = WAIT;
            WAIT:  if (wait_done)   state_nxt = pick_any ? ISSUE : DONE;
            DONE:  if (best_ready)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            sad_mode <= MODE_FIRST;
            run_min  <= '1;
            run_mode <= MODE_FIRST;
        end else if (state == IDLE && start_valid) begin
            pending  <= mode_mask;
            sad_mode <= pick_idx;
            run_min  <= '1;
            run_mode <= MODE_FIRST;
        end else if (wait_done) begin
            // Strict compare keeps the lower-index mode on ties.
            if (eff_sad < run_min) begin
                run_min  <= eff_sad;
                run_mode <= sad_mode;
            end
            pending <= pend_clr;
            if (pick_any) sad_mode <= pick_idx;
        end
    end

    assign start_ready = (state == IDLE);
    assign sad_req     = (state == ISSUE);
    assign best_valid  = (state == DONE);
    assign busy        = (state != IDLE);
    assign best_mode   = run_mode;
    assign best_sad    = run_min;

endmodule

// File: tb/tb_intra_mode_ctrl.sv
// tb/tb_intra_mode_ctrl.sv - scoreboard bench for intra_mode_ctrl; INTRA_TIMEOUT_EN adds the watchdog case
module tb_intra_mode_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [7:0]  mode_mask = '0;
    logic        sad_req;
    logic [2:0]  sad_mode;
    logic        sad_ack = 1'b0;
    logic        sad_valid = 1'b0;
    logic [15:0] sad_value = '0;
    logic        best_valid;
    logic        best_ready = 1'b0;
    logic [2:0]  best_mode;
    logic [15:0] best_sad;
    logic        busy;
    logic        timeout_err;

    intra_mode_ctrl #(.NUM_MODES(8), .SAD_W(16), .TIMEOUT_CYC(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mode_mask   (mode_mask),
        .sad_req     (sad_req),
        .sad_mode    (sad_mode),
        .sad_ack     (sad_ack),
        .sad_valid   (sad_valid),
        .sad_value   (sad_value),
        .best_valid  (best_valid),
        .best_ready  (best_ready),
        .best_mode   (best_mode),
        .best_sad    (best_sad),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic [2:0]  req_q[$];
    logic [18:0] res_q[$];
    logic [15:0] sad_tab[8];
    logic [7:0]  drop = '0;
    int          ack_delay = 0;
    logic        resp_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // SAD engine model: ack after ack_delay cycles, then valid on the first WAIT cycle unless dropped.
    initial begin
        int         phase = 0;
        int         cnt = 0;
        logic [2:0] cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                sad_ack   = 1'b0;
                sad_valid = 1'b0;
                if (phase == 1) begin
                    if (!drop[cur]) begin
                        sad_valid = 1'b1;
                        sad_value = sad_tab[cur];
                    end
                    phase = 0;
                end else if (sad_req) begin
                    if (cnt >= ack_delay) begin
                        sad_ack = 1'b1;
                        cur     = sad_mode;
                        phase   = 1;
                        cnt     = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Monitor: pops expected requests and results on handshakes, checks sad_mode holds while pending.
    initial begin
        logic       prev_pend = 1'b0;
        logic [2:0] prev_mode = '0;
        logic [2:0] em;
        logic [18:0] er;
        forever begin
            @(negedge clk);
            if (prev_pend && sad_req) chk("sad_mode_stable", 32'(sad_mode), 32'(prev_mode));
            if (sad_req && sad_ack) begin
                if (req_q.size() == 0) chk("unexpected_req", 32'(sad_mode), 32'hEE);
                else begin
                    em = req_q.pop_front();
                    chk("req_mode", 32'(sad_mode), 32'(em));
                end
            end
            if (best_valid && best_ready) begin
                if (res_q.size() == 0) chk("unexpected_best", 32'(best_valid), 32'h0);
                else begin
                    er = res_q.pop_front();
                    chk("best_mode", 32'(best_mode), 32'(er[18:16]));
                    chk("best_sad", 32'(best_sad), 32'(er[15:0]));
                end
            end
            prev_pend = sad_req && !sad_ack;
            prev_mode = sad_mode;
        end
    end

    task automatic run(input logic [7:0] mask, input logic [2:0] em, input logic [15:0] es,
                       input int elat, input int rdly);
        int n;
        for (int i = 0; i < 8; i++) if (mask[i]) req_q.push_back(3'(i));
        res_q.push_back({em, es});
        @(posedge clk); #1;
        start_valid = 1'b1;
        mode_mask   = mask;
        @(posedge clk); #1;
        start_valid = 1'b0;
        mode_mask   = ~mask;
        n = 1;
        while (!best_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!best_valid) begin
            chk("best_valid_wait", 32'(best_valid), 32'h1);
            return;
        end
        if (elat > 0) chk("latency", 32'(n), 32'(elat));
        for (int k = 0; k < rdly; k++) begin
            chk("hold_valid", 32'(best_valid), 32'h1);
            chk("hold_mode", 32'(best_mode), 32'(em));
            chk("hold_sad", 32'(best_sad), 32'(es));
            @(posedge clk); #1;
        end
        best_ready = 1'b1;
        @(posedge clk); #1;
        best_ready = 1'b0;
        chk("idle_after_done", 32'(start_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sad_req", 32'(sad_req), 32'h0);
        chk("rst_best_valid", 32'(best_valid), 32'h0);
        chk("rst_best_sad", 32'(best_sad), 32'hFFFF);
        chk("rst_best_mode", 32'(best_mode), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        reset = 1'b1;

        sad_tab = '{16'd40, 16'd30, 16'd30, 16'd50, 16'd20, 16'd20, 16'd90, 16'd25};
        run(8'hFF, 3'd4, 16'd20, 17, 0);

        sad_tab = '{16'd9, 16'd9, 16'd7, 16'd9, 16'd9, 16'd3, 16'd9, 16'd9};
        run(8'b0010_0100, 3'd5, 16'd3, 5, 0);

        run(8'h00, 3'd0, 16'hFFFF, 1, 0);

        sad_tab = '{16'd1, 16'd100, 16'd1, 16'd100, 16'd1, 16'd1, 16'd1, 16'd1};
        ack_delay = 3;
        run(8'b0000_1010, 3'd1, 16'd100, 0, 4);
        ack_delay = 0;

        sad_tab[7] = 16'hFFFF;
        run(8'h80, 3'd0, 16'hFFFF, 3, 1);

        // Abort during WAIT of mode 3.
        sad_tab = '{16'd40, 16'd30, 16'd30, 16'd50, 16'd20, 16'd20, 16'd90, 16'd25};
        drop[3] = 1'b1;
        for (int i = 0; i < 4; i++) req_q.push_back(3'(i));
        @(posedge clk); #1;
        start_valid = 1'b1;
        mode_mask   = 8'hFF;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sad_req && sad_ack && sad_mode == 3'd3) && n < 100);
        chk("reach_mode3", 32'(sad_mode), 32'h3);
        @(posedge clk); #2;
        resp_en = 1'b0;
        reset   = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_start_ready", 32'(start_ready), 32'h1);
        chk("abort_best_valid", 32'(best_valid), 32'h0);
        chk("abort_sad_mode", 32'(sad_mode), 32'h0);
        chk("abort_best_sad", 32'(best_sad), 32'hFFFF);
        @(posedge clk); #2;
        reset     = 1'b1;
        sad_ack   = 1'b0;
        sad_valid = 1'b1;
        sad_value = 16'd1;
        repeat (2) @(posedge clk);
        #2;
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_best_valid", 32'(best_valid), 32'h0);
        chk("stray_sad_req", 32'(sad_req), 32'h0);
        sad_valid = 1'b0;
        drop[3]   = 1'b0;
        resp_en   = 1'b1;

        // Still usable after the abort.
        run(8'b0001_1000, 3'd4, 16'd20, 5, 0);

`ifdef INTRA_TIMEOUT_EN
        sad_tab[0] = 16'd5;
        drop[1]    = 1'b1;
        run(8'h03, 3'd0, 16'd5, 0, 0);
        chk("timeout_err_set", 32'(timeout_err), 32'h1);
        drop[1] = 1'b0;
`else
        chk("timeout_err_tied", 32'(timeout_err), 32'h0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("req_q_drained", 32'(req_q.size()), 32'h0);
        chk("res_q_drained", 32'(res_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
